// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with sequential, PC-relative and
// JALR redirects, stall hold, mret return and misaligned-target trapping.
// Optional build macro PC_SEQ_PERF_CNT_EN adds redirect_cnt and fetch_cnt
// performance counters; without it those ports do not exist.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            pc_src,
    input  logic            jalr,
    input  logic            mret,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic            misalign_trap,
    output logic [XLEN-1:0] mepc
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]     redirect_cnt,
    output logic [31:0]     fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic            valid_q, valid_d;
    logic            trap_q, trap_d;

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            run_active;

    // Candidate addresses: sequential, and the redirect target with JALR bit 0 cleared
    always_comb begin
        seq_pc     = pc_q + XLEN'(4);
        jalr_sum   = rs1 + imm_ext;
        target     = jalr ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : (pc_q + imm_ext);
        run_active = (state_q == ST_RUN) && !stall;
    end

    // Next-state logic; priority in RUN is stall > mret > pc_src > sequential
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mepc_d  = mepc_q;
        trap_d  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                // First valid fetch is the reset vector itself, so pc holds
                state_d = ST_RUN;
            end
            ST_TRAP: begin
                // The trap-vector slot is a bubble; fetching resumes after it
                state_d = ST_RUN;
                pc_d    = seq_pc;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (mret) begin
                        pc_d = mepc_q;
                    end else if (pc_src) begin
                        if (target[1]) begin
                            mepc_d  = pc_q;
                            pc_d    = TRAP_VECTOR;
                            state_d = ST_TRAP;
                            trap_d  = 1'b1;
                        end else begin
                            pc_d = target;
                        end
                    end else begin
                        pc_d = seq_pc;
                    end
                end
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = RESET_VECTOR;
            end
        endcase
        valid_d = (state_d == ST_RUN);
    end

    // Architectural state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            mepc_q  <= '0;
            valid_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mepc_q  <= mepc_d;
            valid_q <= valid_d;
            trap_q  <= trap_d;
        end
    end

    assign pc            = pc_q;
    assign pc_plus4      = seq_pc;
    assign pc_valid      = valid_q;
    assign misalign_trap = trap_q;
    assign mepc          = mepc_q;

`ifdef PC_SEQ_PERF_CNT_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        redirect_take;

    // Count unstalled RUN cycles and accepted non-trapping redirects
    always_comb begin
        redirect_take  = run_active && !mret && pc_src && !target[1];
        fetch_cnt_d    = run_active    ? fetch_cnt_q + 32'd1    : fetch_cnt_q;
        redirect_cnt_d = redirect_take ? redirect_cnt_q + 32'd1 : redirect_cnt_q;
    end

    // Counter registers, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_q <= '0;
            fetch_cnt_q    <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            fetch_cnt_q    <= fetch_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign fetch_cnt    = fetch_cnt_q;
`else
    logic unused_run_active;
    assign unused_run_active = run_active;
`endif

endmodule
